// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  localparam logic [15:0] BAUD_MIN = 16'd2;

  // STATUS only has a 4-bit count field, so deeper FIFOs report 15.
  function automatic logic [3:0] sat_count(input int unsigned c);
    return (c > 15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Register-window bus between the data-memory controller and the UART.
interface uart_tx_mmio_if;
  logic        write_en;
  logic        read_en;
  logic [1:0]  reg_sel;
  logic [31:0] dataw;
  logic [31:0] datar;

  modport master (output write_en, read_en, reg_sel, dataw, input datar);
  modport slave  (input write_en, read_en, reg_sel, dataw, output datar);
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only with a same-cycle pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter behind a small register window (TXDATA / STATUS / BAUDDIV).
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
  output logic          tx,
  output logic          irq_empty
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t   state_q, state_d;
  logic [15:0] baud_div_q, baud_div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic          pop, full, empty, tick, load;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          wr_txdata, wr_status, wr_bauddiv;
  logic          unused_dataw;

  assign unused_dataw = ^bus.dataw[31:16];
  assign wr_txdata    = bus.write_en && (bus.reg_sel == REG_TXDATA);
  assign wr_status    = bus.write_en && (bus.reg_sel == REG_STATUS);
  assign wr_bauddiv   = bus.write_en && (bus.reg_sel == REG_BAUDDIV);
  assign tick         = baud_cnt_q == '0;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (bus.dataw[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && bus.dataw[ST_OVF]) ovf_d = 1'b0;
    if (wr_txdata && full && !pop)      ovf_d = 1'b1;
    baud_div_d = baud_div_q;
    if (wr_bauddiv)
      baud_div_d = (bus.dataw[15:0] < BAUD_MIN) ? BAUD_MIN : bus.dataw[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_div_q <= DIV_RESET;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_div_q <= baud_div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
    end
  end

  // The end of a stop bit with data waiting starts the next frame directly,
  // so back-to-back frames are exactly 10 bit-times apart.
  assign load = !empty && ((state_q == IDLE) || (state_q == STOP && tick));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!empty) state_d = START;
      START: if (tick) state_d = DATA;
      DATA:  if (tick && bit_cnt_q == 3'd7) state_d = STOP;
      STOP:  if (tick) state_d = empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    if (load) begin
      pop        = 1'b1;
      shift_d    = head;
      bit_cnt_d  = '0;
      baud_cnt_d = baud_div_q - 16'd1;
      tx_d       = 1'b0;
    end else if (state_q != IDLE) begin
      if (!tick) begin
        baud_cnt_d = baud_cnt_q - 16'd1;
      end else begin
        baud_cnt_d = (state_q == STOP) ? '0 : baud_div_q - 16'd1;
        case (state_q)
          START: tx_d = shift_q[0];
          DATA: begin
            if (bit_cnt_q == 3'd7) begin
              tx_d = 1'b1;
            end else begin
              shift_d   = {1'b0, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_d      = shift_q[1];
            end
          end
          default: tx_d = 1'b1;
        endcase
      end
    end
  end

  assign tx        = tx_q;
  assign irq_empty = empty && (state_q == IDLE);

  always_comb begin
    bus.datar = '0;
    if (bus.read_en) begin
      case (bus.reg_sel)
        REG_STATUS: begin
          bus.datar[ST_FULL]  = full;
          bus.datar[ST_EMPTY] = empty;
          bus.datar[ST_BUSY]  = state_q != IDLE;
          bus.datar[ST_OVF]   = ovf_q;
          bus.datar[7:4]      = sat_count(32'(count));
        end
        REG_BAUDDIV: bus.datar = {16'b0, baud_div_q};
        default:     bus.datar = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench: drives the register window and decodes the serial line back into bytes.
module tb_uart_tx_mmio;
  localparam logic [1:0] TXD = 2'd0, STS = 2'd1, BDV = 2'd2, RSV = 2'd3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, irq_empty;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0;
  int cur_div = 434;

  logic [7:0] rx_q[$];
  logic       stop_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];

  // Line decoder: samples each bit in the middle of its window.
  int         m_s, m_d, m_off;
  logic [7:0] m_b;
  logic       m_ok;
  always begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      m_s = cyc; m_d = cur_div; m_b = '0; m_ok = 1'b1; m_off = 0;
      while (m_off < 9*m_d + m_d/2) begin
        @(negedge clk);
        if (reset) begin m_ok = 1'b0; break; end
        m_off = cyc - m_s;
        if ((m_off % m_d) == m_d/2 && m_off >= m_d && m_off < 9*m_d)
          m_b[m_off/m_d - 1] = tx;
      end
      if (m_ok) begin
        rx_q.push_back(m_b); stop_q.push_back(tx); start_q.push_back(m_s);
      end
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    bus.write_en = 1'b1; bus.reg_sel = sel; bus.dataw = d;
    @(negedge clk);
    bus.write_en = 1'b0;
    if (sel == BDV) cur_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
  endtask

  task automatic rd(input logic [1:0] sel, output logic [31:0] v);
    bus.read_en = 1'b1; bus.reg_sel = sel;
    #1 v = bus.datar;
    bus.read_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (irq_empty !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (irq_empty !== 1'b1) $display("FAIL %s: irq_empty=%b after %0d cycles, want 1", name, irq_empty, n);
    else passes++;
  endtask

  task automatic clear_q();
    rx_q.delete(); stop_q.delete(); start_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; cur_div = 434;
    rd(STS, v); checks++;
    if (v !== 32'h2) $display("FAIL reset_status: got %h want 00000002", v); else passes++;
    rd(BDV, v); checks++;
    if (v !== 32'd434) $display("FAIL reset_baud: got %0d want 434", v); else passes++;
    checks++;
    if (tx !== 1'b1 || irq_empty !== 1'b1) $display("FAIL reset_pins: tx=%b irq=%b want 1 1", tx, irq_empty); else passes++;
    bus.reg_sel = BDV; #1; checks++;
    if (bus.datar !== 32'h0) $display("FAIL datar_noread: got %h want 0", bus.datar); else passes++;
    rd(RSV, v); checks++;
    if (v !== 32'h0) $display("FAIL read_reserved: got %h want 0", v); else passes++;
    rd(TXD, v); checks++;
    if (v !== 32'h0) $display("FAIL read_txdata: got %h want 0", v); else passes++;
    @(negedge clk);
  endtask

  task automatic test_frame();
    logic [31:0] v;
    logic e;
    int b, bad;
    clear_q();
    wr(BDV, 32'd4);
    wr(TXD, 32'hA5); exp_q.push_back(8'hA5);
    rd(STS, v); checks++;
    if (v !== 32'h10 || tx !== 1'b1) $display("FAIL push_visible: status=%h tx=%b want 00000010 1", v, tx); else passes++;
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      b = t / 4;
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : 1'((8'hA5 >> (b - 1)) & 8'h1);
      rd(STS, v);
      if (tx !== e || v[2] !== 1'b1) begin
        bad++;
        if (bad < 4) $display("FAIL frame_wave t=%0d: tx=%b busy=%b want %b 1", t, tx, v[2], e);
      end
    end
    checks++; if (bad == 0) passes++;
    @(negedge clk);
    rd(STS, v); checks++;
    if (v !== 32'h2 || irq_empty !== 1'b1) $display("FAIL frame_end: status=%h irq=%b want 00000002 1", v, irq_empty); else passes++;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL frame_rx: got %0d bytes first %h want 1 a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h0);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int n0;
    clear_q();
    wr(BDV, 32'd2);
    wr(TXD, 32'h01); n0 = cyc;
    wr(TXD, 32'h02); wr(TXD, 32'h03);
    exp_q = '{8'h01, 8'h02, 8'h03};
    while (cyc < n0 + 20) @(negedge clk);
    rd(STS, v); checks++;
    if (v !== 32'h24) $display("FAIL b2b_count2: got %h want 00000024", v); else passes++;
    @(negedge clk); rd(STS, v); checks++;
    if (v !== 32'h14) $display("FAIL b2b_count1: got %h want 00000014", v); else passes++;
    while (cyc < n0 + 41) @(negedge clk);
    rd(STS, v); checks++;
    if (v !== 32'h06) $display("FAIL b2b_count0: got %h want 00000006", v); else passes++;
    while (cyc < n0 + 61) @(negedge clk);
    rd(STS, v); checks++;
    if (v !== 32'h02 || irq_empty !== 1'b1) $display("FAIL b2b_idle: status=%h irq=%b want 00000002 1", v, irq_empty); else passes++;
    checks++;
    if (rx_q.size() != 3 || start_q[0] != n0 + 1 || start_q[1] - start_q[0] != 20 || start_q[2] - start_q[1] != 20)
      $display("FAIL b2b_timing: frames=%0d want 3 contiguous 20-cycle frames from cycle %0d", rx_q.size(), n0 + 1);
    else passes++;
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0] d;
    clear_q();
    wr(BDV, 32'd100);
    // One byte leaves for the shifter on the first pop, so DEPTH+1 fit.
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      wr(TXD, {24'h0, d});
      if (i < DEPTH + 1) exp_q.push_back(d);
    end
    rd(STS, v); checks++;
    if (v !== 32'h8D) $display("FAIL ovf_set: got %h want 0000008d", v); else passes++;
    wr(STS, 32'h8);
    rd(STS, v); checks++;
    if (v !== 32'h85) $display("FAIL ovf_clear: got %h want 00000085", v); else passes++;
    wait_idle(12000, "ovf_drain");
    checks++;
    if (rx_q.size() != exp_q.size()) $display("FAIL ovf_frames: got %0d want %0d", rx_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    int n0, lows;
    clear_q();
    wr(BDV, 32'd0);
    rd(BDV, v); checks++;
    if (v !== 32'd2) $display("FAIL baud_clamp: got %0d want 2", v); else passes++;
    wr(TXD, 32'h55); n0 = cyc;
    for (int i = 0; i < 3; i++) wr(TXD, {24'h0, 8'($urandom)});
    while (cyc < n0 + 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || irq_empty !== 1'b1) $display("FAIL midreset_pins: tx=%b irq=%b want 1 1", tx, irq_empty); else passes++;
    reset = 1'b0; cur_div = 434;
    rd(STS, v); checks++;
    if (v !== 32'h2) $display("FAIL midreset_status: got %h want 00000002", v); else passes++;
    rd(BDV, v); checks++;
    if (v !== 32'd434) $display("FAIL midreset_baud: got %0d want 434", v); else passes++;
    lows = 0;
    repeat (60) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0 || rx_q.size() != 0) $display("FAIL midreset_quiet: low cycles=%0d frames=%0d want 0 0", lows, rx_q.size());
    else passes++;
  endtask

  task automatic test_pop_push();
    logic [31:0] v;
    logic [7:0] d;
    int n0;
    clear_q();
    wr(BDV, 32'd2);
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = 8'($urandom); wr(TXD, {24'h0, d}); exp_q.push_back(d);
      if (i == 0) n0 = cyc;
    end
    while (cyc < n0 + 20) @(negedge clk);
    rd(STS, v); checks++;
    if (v !== 32'h85) $display("FAIL pp_full: got %h want 00000085", v); else passes++;
    // This write lands on the edge where the stop bit ends and the head pops.
    d = 8'($urandom); wr(TXD, {24'h0, d}); exp_q.push_back(d);
    rd(STS, v); checks++;
    if (v !== 32'h85) $display("FAIL pp_accept: got %h want 00000085", v); else passes++;
    wr(TXD, 32'hEE);
    rd(STS, v); checks++;
    if (v !== 32'h8D) $display("FAIL pp_ovf: got %h want 0000008d", v); else passes++;
    wr(STS, 32'h8);
    wait_idle(400, "pp_drain");
    checks++;
    if (rx_q.size() != exp_q.size()) $display("FAIL pp_frames: got %0d want %0d", rx_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL pp_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int div, n;
    for (int r = 0; r < 3; r++) begin
      clear_q();
      div = $urandom_range(2, 6);
      wr(BDV, 32'(div));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom); wr(TXD, {24'h0, d}); exp_q.push_back(d);
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_idle(2000, "rand_drain");
      checks++;
      if (rx_q.size() != n) $display("FAIL rand_frames r=%0d: got %0d want %0d", r, rx_q.size(), n); else passes++;
      for (int i = 0; i < n && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i] || stop_q[i] !== 1'b1 || (i > 0 && start_q[i] - start_q[i-1] < 10*div))
          $display("FAIL rand_byte r=%0d i=%0d: got %h stop=%b want %h stop=1", r, i, rx_q[i], stop_q[i], exp_q[i]);
        else passes++;
      end
    end
  endtask

  initial begin
    bus.write_en = 1'b0; bus.read_en = 1'b0; bus.reg_sel = '0; bus.dataw = '0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_pop_push();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
